// File: rtl/rtdf_sample_conditioner.sv
// rtdf_sample_conditioner
//   Conditions the 3-bit sign/magnitude sample stream from the real-time data
//   feed: primes on a run of consecutive valid samples, maps codes to signed
//   4-bit values, fills short underruns with filler samples, declares stream
//   loss on long gaps and produces a 1 ms epoch tick with a sample index.
//
//   Optional build macro: RTDF_SAMPLE_HOLD_EN
//     defined   -> filler samples repeat the last real output value
//     undefined -> filler samples are 4'h0
//
//   All outputs are registered: an input accepted in cycle N is reflected on
//   the outputs in cycle N+1.
module rtdf_sample_conditioner #(
    parameter int PRIME_COUNT    = 16,
    parameter int GAP_TOL        = 4,
    parameter int SAMPLES_PER_MS = 16368,
    parameter int IDX_W          = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_data,
    input  logic             clear_counts,
    output logic             out_valid,
    output logic [3:0]       out_data,
    output logic             out_fill,
    output logic             ms_tick,
    output logic [IDX_W-1:0] sample_index,
    output logic             stream_active,
    output logic             lost_pulse,
    output logic [15:0]      underrun_count,
    output logic [7:0]       lost_count
);

    // prime_cnt counts 0..PRIME_COUNT-1; the sample that would make it reach
    // PRIME_COUNT moves the FSM to STREAM instead of being stored.
    localparam int PRIME_W = (PRIME_COUNT > 1) ? $clog2(PRIME_COUNT) : 1;
    // gap_cnt counts 1..GAP_TOL while in GAP.
    localparam int GAP_W   = $clog2(GAP_TOL + 1);

    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_COUNT - 1);
    localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(GAP_TOL);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(SAMPLES_PER_MS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t             state_q;
    logic [PRIME_W-1:0] prime_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [IDX_W-1:0]   next_idx_q;     // index the next emitted sample will carry

    logic               out_valid_q;
    logic [3:0]         out_data_q;
    logic               out_fill_q;
    logic               ms_tick_q;
    logic [IDX_W-1:0]   sample_index_q;
    logic               stream_active_q;
    logic               lost_pulse_q;
    logic [15:0]        underrun_count_q;
    logic [7:0]         lost_count_q;

    logic [3:0]         mapped_d;
    logic [3:0]         fill_val_d;
    logic               emit_real_d;
    logic               emit_fill_d;
    logic               lose_d;
    logic               prime_done_d;
    logic               active_d;
    logic [IDX_W-1:0]   idx_wrap_d;
    logic [15:0]        underrun_sat_d;
    logic [7:0]         lost_sat_d;

`ifdef RTDF_SAMPLE_HOLD_EN
    logic [3:0]         hold_q;         // last real sample, survives loss/re-prime
`endif

    // Sign/magnitude code to odd two's-complement value: +/-(2m+1).
    always_comb begin
        logic [3:0] pos;
        pos      = {1'b0, in_data[1:0], 1'b1};
        mapped_d = in_data[2] ? (~pos + 4'd1) : pos;
    end

    // Value carried by filler samples.
`ifdef RTDF_SAMPLE_HOLD_EN
    assign fill_val_d = hold_q;
`else
    assign fill_val_d = 4'h0;
`endif

    // Per-cycle decisions shared by the FSM, the epoch counter and the stats.
    always_comb begin
        emit_real_d  = in_valid && ((state_q == STREAM) || (state_q == GAP));
        emit_fill_d  = !in_valid && ((state_q == STREAM) ||
                                     ((state_q == GAP) && (gap_cnt_q != GAP_MAX)));
        lose_d       = !in_valid && (state_q == GAP) && (gap_cnt_q == GAP_MAX);
        prime_done_d = in_valid && (((state_q == IDLE) && (PRIME_COUNT == 1)) ||
                                    ((state_q == PRIME) && (prime_cnt_q == PRIME_LAST)));
        // Next state will be STREAM or GAP exactly when we emit or finish priming.
        active_d     = emit_real_d || emit_fill_d || prime_done_d;
        idx_wrap_d   = (next_idx_q == IDX_LAST) ? '0 : next_idx_q + 1'b1;
        underrun_sat_d = (&underrun_count_q) ? underrun_count_q : underrun_count_q + 16'd1;
        lost_sat_d     = (&lost_count_q)     ? lost_count_q     : lost_count_q + 8'd1;
    end

    // Stream FSM with its registered outputs, epoch index and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            prime_cnt_q      <= '0;
            gap_cnt_q        <= '0;
            next_idx_q       <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= 4'h0;
            out_fill_q       <= 1'b0;
            ms_tick_q        <= 1'b0;
            sample_index_q   <= '0;
            stream_active_q  <= 1'b0;
            lost_pulse_q     <= 1'b0;
            underrun_count_q <= '0;
            lost_count_q     <= '0;
`ifdef RTDF_SAMPLE_HOLD_EN
            hold_q           <= 4'h0;
`endif
        end else begin
            // State and priming/gap counters.
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (PRIME_COUNT == 1) begin
                            state_q     <= STREAM;
                            prime_cnt_q <= '0;
                        end else begin
                            state_q     <= PRIME;
                            prime_cnt_q <= PRIME_W'(1);
                        end
                    end
                end
                PRIME: begin
                    if (!in_valid) begin
                        state_q     <= IDLE;
                        prime_cnt_q <= '0;
                    end else if (prime_cnt_q == PRIME_LAST) begin
                        state_q     <= STREAM;
                        prime_cnt_q <= '0;
                    end else begin
                        prime_cnt_q <= prime_cnt_q + 1'b1;
                    end
                end
                STREAM: begin
                    if (!in_valid) begin
                        state_q   <= GAP;
                        gap_cnt_q <= GAP_W'(1);
                    end
                end
                GAP: begin
                    if (in_valid) begin
                        state_q   <= STREAM;
                        gap_cnt_q <= '0;
                    end else if (gap_cnt_q != GAP_MAX) begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end else begin
                        state_q     <= PRIME;
                        prime_cnt_q <= '0;
                        gap_cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Sample outputs: real data, filler, or nothing.
            out_valid_q     <= emit_real_d || emit_fill_d;
            out_fill_q      <= emit_fill_d;
            out_data_q      <= emit_real_d ? mapped_d : (emit_fill_d ? fill_val_d : 4'h0);
            lost_pulse_q    <= lose_d;
            stream_active_q <= active_d;
            ms_tick_q       <= 1'b0;

            // Epoch index: advances per emitted sample, restarts on loss.
            if (lose_d) begin
                next_idx_q     <= '0;
                sample_index_q <= '0;
            end else if (emit_real_d || emit_fill_d) begin
                sample_index_q <= next_idx_q;
                ms_tick_q      <= (next_idx_q == IDX_LAST);
                next_idx_q     <= idx_wrap_d;
            end

            // Saturating statistics; clear wins over a same-cycle increment.
            if (clear_counts)     underrun_count_q <= '0;
            else if (emit_fill_d) underrun_count_q <= underrun_sat_d;

            if (clear_counts)     lost_count_q <= '0;
            else if (lose_d)      lost_count_q <= lost_sat_d;

`ifdef RTDF_SAMPLE_HOLD_EN
            if (emit_real_d) hold_q <= mapped_d;
`endif
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_fill       = out_fill_q;
    assign ms_tick        = ms_tick_q;
    assign sample_index   = sample_index_q;
    assign stream_active  = stream_active_q;
    assign lost_pulse     = lost_pulse_q;
    assign underrun_count = underrun_count_q;
    assign lost_count     = lost_count_q;

endmodule

// File: doc/rtdf_sample_conditioner.md
Name: rtdf_sample_conditioner

Overview:
Sits directly downstream of the real-time data feed, in the clk_sample domain. Consumes its 3-bit sample_valid/sample_data stream and primes on a run of consecutive valid samples. Converts sign/magnitude codes to signed 4-bit values and fills short underruns with filler samples so sample timing is preserved. Declares stream loss on long gaps and produces a 1 ms epoch tick for the tracking channels.

Parameters:
PRIME_COUNT, 16, consecutive valid input samples required before output starts (≥1)
GAP_TOL, 4, max consecutive missing samples filled before stream loss (≥1)
SAMPLES_PER_MS, 16368, samples per 1 ms epoch
IDX_W, 14, width of sample_index (2^IDX_W ≥ SAMPLES_PER_MS)

Ports:
clk  in  1  sample clock (clk_sample domain)
reset  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid (sample_valid from feed)
in_data  in  3  [2]=sign (1=negative), [1:0]=magnitude code m
clear_counts  in  1  synchronous clear of underrun_count and lost_count
out_valid  out  1  output sample strobe
out_data  out  4  signed two's-complement sample
out_fill  out  1  out_data is filler, not real data
ms_tick  out  1  high with the last sample of each 1 ms epoch
sample_index  out  IDX_W  index of the current output sample within the epoch
stream_active  out  1  high in STREAM/GAP
lost_pulse  out  1  one-cycle pulse on stream loss
underrun_count  out  16  filled samples, saturating
lost_count  out  8  loss events, saturating

Behaviour:
- Reset: state IDLE; every output and counter 0.
- Mapping: value = +(2m+1) if sign=0, −(2m+1) if sign=1. Range ±1, ±3, ±5, ±7 (e.g. 3'b000→4'h1, 3'b111→4'h9 = −7).
- Latency: all outputs registered. An input accepted in cycle N appears on out_* in cycle N+1.
- IDLE: in_valid=1 → PRIME, prime_cnt=1. Sample discarded.
- PRIME: in_valid=1 → prime_cnt++. in_valid=0 → prime_cnt=0, back to IDLE. When the valid sample makes prime_cnt reach PRIME_COUNT → STREAM. All priming samples are discarded, so the first output is input sample PRIME_COUNT+1.
- STREAM:
  - in_valid=1: out_valid=1, out_fill=0, out_data=mapped.
  - in_valid=0: → GAP with gap_cnt=1; emit filler (out_valid=1, out_fill=1, out_data=0); underrun_count++.
- GAP:
  - in_valid=1: → STREAM, real sample output, gap_cnt=0.
  - in_valid=0 with gap_cnt<GAP_TOL: gap_cnt++, emit filler, underrun_count++.
  - in_valid=0 with gap_cnt=GAP_TOL: no output; lost_pulse=1; lost_count++; → PRIME with prime_cnt=0; sample_index=0.
  - Result: exactly GAP_TOL fillers, then loss on missing sample GAP_TOL+1.
- Epoch counter: the first output after priming has sample_index=0. Index increments by 1 per output, real or filler. The output with index SAMPLES_PER_MS−1 carries ms_tick=1, and the next output has index 0. Index holds when no output.
- stream_active=1 in STREAM and GAP, 0 otherwise (registered with outputs).
- Counters saturate at all-ones. clear_counts takes priority over an increment in the same cycle (result 0).
- reset asserted mid-stream: next cycle IDLE, all outputs 0, no lost_pulse.

Optional Feature:
Macro RTDF_SAMPLE_HOLD_EN.
- Defined: filler samples repeat the last real out_data instead of 0 (out_fill still 1). A register holds the last real sample; it resets to 0 and is retained across loss/re-prime.
- Undefined: filler out_data=4'h0.

Test Plan:
- Reset, then PRIME_COUNT=16 valid samples, then valid 3'b010 → no out_valid during priming. Cycle after the 17th sample is accepted: out_valid=1, out_data=4'h5, sample_index=0, stream_active=1.
- Sweep all 8 in_data codes in STREAM → out_data 1, 3, 5, 7, −1, −3, −5, −7 (4'h1, 4'h3, 4'h5, 4'h7, 4'hF, 4'hD, 4'hB, 4'h9), one cycle later, out_fill=0.
- In STREAM, drop in_valid for 2 cycles → two fillers (out_fill=1, out_data=0, or held value with RTDF_SAMPLE_HOLD_EN); underrun_count=2; index advances by 2; stream resumes without lost_pulse.
- Drop in_valid for 5 cycles with GAP_TOL=4 → 4 fillers, lost_pulse on the 5th missing cycle, lost_count=1, stream_active=0. Re-priming requires 16 new valid samples; the index restarts at 0.
- Continuous valid for 2×16368 outputs → ms_tick high exactly on index 16367 twice; the following sample shows index 0.
- Force underrun_count to 16'hFFFF via long gap/resume cycles, then one more filler → stays 16'hFFFF. clear_counts concurrent with a filler → 0.
